// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types and constants for the keystream path.
// Holds the block layout and the keystream_sequencer state encoding.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] block_t;

  localparam int    BLOCK_BYTES   = 64;
  localparam word_t BLOCK_CTR_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_FIN    = 3'd4
  } ks_state_t;

  // RFC 8439 serialisation: word idx[5:2] at [w/4][w%4], little-endian bytes.
  function automatic logic [7:0] block_byte(input block_t b, input logic [5:0] idx);
    word_t w;
    w = b[idx[5:4]][idx[3:2]];
    return w[{idx[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ks_block_buffer.sv
// One 16-word keystream block register with a load strobe and a byte read mux.
module ks_block_buffer
  import chacha_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  block_t     block_in,
  input  logic [5:0] byte_idx,
  output logic [7:0] byte_out
);

  block_t blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= '0;
    end else if (load) begin
      blk <= block_in;
    end
  end

  assign byte_out = block_byte(blk, byte_idx);

endmodule

// File: rtl/keystream_sequencer.sv
// Requests ChaCha20 blocks and streams msg_len keystream bytes over valid/ready.
// Define KS_PREFETCH_EN for a ping-pong buffer that fetches the next block early.
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | core_start pulse for blk_ctr
// WAIT   | waiting for core_done
// STREAM | emitting bytes of the current block
// FIN    | one-cycle done pulse
module keystream_sequencer
  import chacha_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      init_counter,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_start,
  output logic [31:0]      core_counter,
  input  logic             core_done,
  input  block_t           core_block,
  output logic [7:0]       ks_byte,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             ks_last
);

  ks_state_t        state, state_nxt;
  logic [LEN_W-1:0] remaining;
  word_t            blk_ctr;
  logic [5:0]       byte_idx;
  logic             err_q;
  logic [7:0]       rd_byte;

  logic start_ok, accept, last_beat, blk_end, ctr_ovf, boundary;
  logic err_set, ctr_step, block_in;

  assign start_ok  = (state == S_IDLE) && start;
  assign accept    = (state == S_STREAM) && ks_ready;
  assign last_beat = (remaining == LEN_W'(1));
  assign blk_end   = (byte_idx == 6'(BLOCK_BYTES - 1));
  assign ctr_ovf   = (blk_ctr == BLOCK_CTR_MAX);
  assign boundary  = accept && blk_end && !last_beat;
  assign block_in  = (state == S_WAIT) && core_done;

`ifdef KS_PREFETCH_EN
  logic       cur_sel, pf_out, pf_held, pf_start;
  logic       pf_fire, pf_land, next_ready;
  logic       load0, load1;
  logic [7:0] rd0, rd1;

  // Prefetch on the first beat of a block, only if bytes remain past this block.
  assign pf_fire    = accept && (byte_idx == 6'd0) &&
                      (remaining > LEN_W'(BLOCK_BYTES)) && !ctr_ovf;
  assign pf_land    = (state == S_STREAM) && pf_out && core_done;
  assign next_ready = pf_held || pf_land;

  assign load0 = (block_in && !cur_sel) || (pf_land && cur_sel);
  assign load1 = (block_in && cur_sel) || (pf_land && !cur_sel);

  ks_block_buffer u_buf0 (
    .clk(clk), .rst(rst), .load(load0), .block_in(core_block),
    .byte_idx(byte_idx), .byte_out(rd0)
  );

  ks_block_buffer u_buf1 (
    .clk(clk), .rst(rst), .load(load1), .block_in(core_block),
    .byte_idx(byte_idx), .byte_out(rd1)
  );

  assign rd_byte = cur_sel ? rd1 : rd0;

  // blk_ctr tracks the most recently requested block, so it steps at issue.
  assign ctr_step = pf_fire;
  assign err_set  = boundary && !next_ready && !pf_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel  <= 1'b0;
      pf_out   <= 1'b0;
      pf_held  <= 1'b0;
      pf_start <= 1'b0;
    end else if (start_ok) begin
      cur_sel  <= 1'b0;
      pf_out   <= 1'b0;
      pf_held  <= 1'b0;
      pf_start <= 1'b0;
    end else begin
      pf_start <= pf_fire;
      if (pf_fire) begin
        pf_out <= 1'b1;
      end else if (pf_land || block_in) begin
        pf_out <= 1'b0;
      end
      if (boundary) begin
        cur_sel <= ~cur_sel;
        pf_held <= 1'b0;
      end else if (pf_land) begin
        pf_held <= 1'b1;
      end
    end
  end
`else
  ks_block_buffer u_buf0 (
    .clk(clk), .rst(rst), .load(block_in), .block_in(core_block),
    .byte_idx(byte_idx), .byte_out(rd_byte)
  );

  assign ctr_step = boundary && !ctr_ovf;
  assign err_set  = boundary && ctr_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (msg_len == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept && last_beat) begin
          state_nxt = S_FIN;
        end else if (boundary) begin
`ifdef KS_PREFETCH_EN
          if (next_ready) begin
            state_nxt = S_STREAM;
          end else if (pf_out) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_FIN;
          end
`else
          state_nxt = ctr_ovf ? S_FIN : S_REQ;
`endif
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_FIN);
    core_start = (state == S_REQ);
`ifdef KS_PREFETCH_EN
    core_start = core_start || pf_start;
`endif
    ks_valid   = (state == S_STREAM);
    ks_last    = (state == S_STREAM) && last_beat;
    ks_byte    = (state == S_STREAM) ? rd_byte : 8'h00;
  end

  assign core_counter = blk_ctr;
  assign err          = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      blk_ctr   <= '0;
      byte_idx  <= '0;
      err_q     <= 1'b0;
    end else if (start_ok) begin
      remaining <= msg_len;
      blk_ctr   <= init_counter;
      byte_idx  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (block_in) begin
        byte_idx <= '0;
      end
      if (accept) begin
        remaining <= remaining - LEN_W'(1);
        byte_idx  <= byte_idx + 6'd1;
      end
      if (ctr_step) begin
        blk_ctr <= blk_ctr + 32'd1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keystream_sequencer.sv
// Directed vector bench for keystream_sequencer with a fixed-latency core model.
module tb_keystream_sequencer;
  import chacha_pkg::*;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [31:0]      init_counter = '0;
  logic             busy, done, err, core_start;
  logic [31:0]      core_counter;
  logic             core_done = 1'b0;
  block_t           core_block = '0;
  logic [7:0]       ks_byte;
  logic             ks_valid;
  logic             ks_ready = 1'b0;
  logic             ks_last;

  int checks = 0;
  int errors = 0;

  bit          core_en = 1'b1;
  int          n_starts = 0;
  logic [31:0] ctr_log [8];

  keystream_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .init_counter(init_counter), .busy(busy), .done(done), .err(err),
    .core_start(core_start), .core_counter(core_counter),
    .core_done(core_done), .core_block(core_block),
    .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .ks_last(ks_last)
  );

  always #5 clk = ~clk;

  // Keystream content as a function of block counter and byte position.
  function automatic logic [7:0] mk_byte(input logic [31:0] c, input int k);
    logic [31:0] v;
    v = 32'(k) + (c - 32'd1) * 32'd64;
    return v[7:0];
  endfunction

  function automatic block_t mk_block(input logic [31:0] c);
    block_t b;
    for (int w = 0; w < 16; w++)
      for (int j = 0; j < 4; j++)
        b[w / 4][w % 4][8 * j +: 8] = mk_byte(c, 4 * w + j);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Core model: three cycles after a core_start, return the block for its counter.
  initial begin
    forever begin
      @(negedge clk);
      if (core_en && core_start) begin
        if (n_starts < 8) ctr_log[n_starts] = core_counter;
        n_starts++;
        repeat (3) @(negedge clk);
        core_block = mk_block(ctr_log[(n_starts - 1) % 8]);
        core_done  = 1'b1;
        @(negedge clk);
        core_done  = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] len;
    logic [31:0] ctr;
    bit          rnd;
    int          exp_starts;
    int          exp_beats;
    int          exp_last;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input int id, input vec_t v);
    int   beats, last_cnt, done_cyc, last_acc_cyc, busy_cyc, cyc;
    logic prev_stall, prev_last;
    logic [7:0] prev_byte, exp_b;
    logic [31:0] blk_c;
    beats = 0; last_cnt = 0; done_cyc = -1; last_acc_cyc = -1; busy_cyc = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_byte = 8'h00;
    n_starts = 0;
    @(negedge clk);
    msg_len = v.len; init_counter = v.ctr; start = 1'b1; ks_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 3000) begin
      ks_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_cyc++;
      if (prev_stall) begin
        chk($sformatf("v%0d stall_byte", id), {24'h0, ks_byte}, {24'h0, prev_byte});
        chk($sformatf("v%0d stall_last", id), {31'h0, ks_last}, {31'h0, prev_last});
      end
      if (ks_valid && ks_ready) begin
        blk_c = v.ctr + 32'(beats / 64);
        exp_b = mk_byte(blk_c, beats % 64);
        chk($sformatf("v%0d byte%0d", id, beats), {24'h0, ks_byte}, {24'h0, exp_b});
        if (ks_last) begin
          last_cnt++;
          chk($sformatf("v%0d last_pos", id), 32'(beats), 32'(v.len) - 32'd1);
        end
        beats++;
        last_acc_cyc = cyc;
      end
      prev_stall = ks_valid && !ks_ready;
      prev_byte  = ks_byte;
      prev_last  = ks_last;
      if (done) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d done_seen", id), {31'h0, done_cyc >= 0}, 32'd1);
    chk($sformatf("v%0d done_width", id), {31'h0, done}, 32'd0);
    chk($sformatf("v%0d busy_after", id), {31'h0, busy}, 32'd0);
    chk($sformatf("v%0d beats", id), 32'(beats), 32'(v.exp_beats));
    chk($sformatf("v%0d last_cnt", id), 32'(last_cnt), 32'(v.exp_last));
    chk($sformatf("v%0d err", id), {31'h0, err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d n_starts", id), 32'(n_starts), 32'(v.exp_starts));
    for (int i = 0; i < v.exp_starts && i < n_starts && i < 8; i++)
      chk($sformatf("v%0d ctr%0d", id, i), ctr_log[i], v.ctr + 32'(i));
    if (v.len == 16'd0) begin
      chk($sformatf("v%0d done_lat", id), 32'(done_cyc), 32'd1);
      chk($sformatf("v%0d busy_cyc", id), 32'(busy_cyc), 32'd1);
    end else begin
      chk($sformatf("v%0d done_lat", id), 32'(done_cyc), 32'(last_acc_cyc + 1));
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{len: 16'd64,  ctr: 32'd1,         rnd: 1'b0, exp_starts: 1, exp_beats: 64,  exp_last: 1, exp_err: 1'b0};
    vecs[1] = '{len: 16'd130, ctr: 32'd7,         rnd: 1'b0, exp_starts: 3, exp_beats: 130, exp_last: 1, exp_err: 1'b0};
    vecs[2] = '{len: 16'd10,  ctr: 32'd3,         rnd: 1'b1, exp_starts: 1, exp_beats: 10,  exp_last: 1, exp_err: 1'b0};
    vecs[3] = '{len: 16'd0,   ctr: 32'd5,         rnd: 1'b0, exp_starts: 0, exp_beats: 0,   exp_last: 0, exp_err: 1'b0};
    vecs[4] = '{len: 16'd65,  ctr: 32'd2,         rnd: 1'b1, exp_starts: 2, exp_beats: 65,  exp_last: 1, exp_err: 1'b0};
    vecs[5] = '{len: 16'd100, ctr: 32'hFFFF_FFFF, rnd: 1'b0, exp_starts: 1, exp_beats: 64,  exp_last: 0, exp_err: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst busy", {31'h0, busy}, 32'd0);
    chk("rst done", {31'h0, done}, 32'd0);
    chk("rst err", {31'h0, err}, 32'd0);
    chk("rst core_start", {31'h0, core_start}, 32'd0);
    chk("rst core_counter", core_counter, 32'd0);
    chk("rst ks_valid", {31'h0, ks_valid}, 32'd0);
    chk("rst ks_last", {31'h0, ks_last}, 32'd0);
    chk("rst ks_byte", {24'h0, ks_byte}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // err stays set after the overflow message until the next start.
    repeat (2) @(negedge clk);
    chk("err sticky", {31'h0, err}, 32'd1);

    // Reset while waiting on the core; the late core_done must be ignored.
    core_en = 1'b0;
    @(negedge clk);
    msg_len = 16'd64; init_counter = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid core_start", {31'h0, core_start}, 32'd1);
    @(negedge clk);
    chk("mid busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_block = mk_block(32'd1);
    core_done  = 1'b1;
    @(negedge clk);
    core_done  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mid_rst busy c%0d", c), {31'h0, busy}, 32'd0);
      chk($sformatf("mid_rst done c%0d", c), {31'h0, done}, 32'd0);
      chk($sformatf("mid_rst err c%0d", c), {31'h0, err}, 32'd0);
      chk($sformatf("mid_rst ks_valid c%0d", c), {31'h0, ks_valid}, 32'd0);
      chk($sformatf("mid_rst core_start c%0d", c), {31'h0, core_start}, 32'd0);
      chk($sformatf("mid_rst core_counter c%0d", c), core_counter, 32'd0);
      chk($sformatf("mid_rst ks_byte c%0d", c), {24'h0, ks_byte}, 32'd0);
      chk($sformatf("mid_rst ks_last c%0d", c), {31'h0, ks_last}, 32'd0);
      @(negedge clk);
    end
    core_en = 1'b1;
    run_vec(6, '{len: 16'd4, ctr: 32'd11, rnd: 1'b0, exp_starts: 1, exp_beats: 4, exp_last: 1, exp_err: 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keystream_sequencer.md
Name: keystream_sequencer

Overview:
- Controller between the ChaCha20 block core and the byte-stream consumer (XOR stage / Poly1305 feed).
- On `start`, it requests successive 64-byte keystream blocks from the core, incrementing the 32-bit block counter for each one.
- Each returned block is captured and emitted one byte per beat over a valid/ready handshake, until `msg_len` bytes have been delivered.
- Adds the backpressure and length control that a free-running serialiser lacks.

Parameters:
- LEN_W, 16, width of the message byte-length field; maximum message is 2^LEN_W-1 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a message; sampled only in IDLE
- msg_len  in  LEN_W  message length in bytes; captured on accepted `start`
- init_counter  in  32  first ChaCha block counter; captured on accepted `start`
- busy  out  1  high from accepted `start` until `done`
- done  out  1  one-cycle pulse when the message completes or aborts
- err  out  1  sticky counter-overflow flag; cleared on next accepted `start`
- core_start  out  1  one-cycle pulse requesting one block
- core_counter  out  32  block counter for the request; stable while the request is outstanding
- core_done  in  1  one-cycle pulse; `core_block` valid in the same cycle
- core_block  in  word_t[3:0][3:0]  block state; word w = [w/4][w%4]
- ks_byte  out  8  keystream byte
- ks_valid  out  1  `ks_byte` valid
- ks_ready  in  1  consumer accepts when `ks_valid` and `ks_ready` are both high
- ks_last  out  1  high with the final byte of the message

Behaviour:
- Reset values: busy=0, done=0, err=0, core_start=0, core_counter=0, ks_valid=0, ks_last=0, ks_byte=0. State returns to IDLE. Reset mid-message abandons the message: no `done` pulse, and a later `core_done` is ignored.
- States: IDLE, REQ, WAIT, STREAM, FIN.
- IDLE:
  - On `start` with `msg_len` != 0: capture `msg_len` into `remaining` and `init_counter` into `blk_ctr`; clear `err`; go to REQ.
  - On `start` with `msg_len` == 0: go to FIN; no `core_start` is issued.
  - `start` outside IDLE is ignored.
- REQ: drive `core_start`=1 for exactly one cycle with `core_counter`=`blk_ctr`; go to WAIT.
- WAIT: on `core_done`, register `core_block` into the 16-word buffer and set `byte_idx`=0; go to STREAM. `ks_valid` rises in the cycle after `core_done`.
- STREAM byte order (RFC 8439 serialisation):
  - word w = `byte_idx[5:2]`, taken from buffer [w/4][w%4].
  - Byte within the word is little-endian: `byte_idx[1:0]`=0 selects bits [7:0], …, 3 selects bits [31:24].
- STREAM handshake:
  - `ks_valid`=1; `ks_byte` and `ks_last` are held stable while `ks_ready`=0.
  - Each accepted beat increments `byte_idx` and decrements `remaining`.
  - `ks_last` = (`remaining` == 1).
- Accept with `remaining` == 1: go to FIN.
- Accept with `byte_idx` == 63 and `remaining` > 1:
  - If `blk_ctr` == 32'hFFFF_FFFF: set `err`=1 and go to FIN; the partial message ends without `ks_last`.
  - Otherwise: `blk_ctr` increments by 1 (modulo 2^32 is not allowed) and the state goes to REQ.
  - `ks_valid` drops between blocks.
- FIN: `done`=1 for one cycle, `busy`=0 in the next cycle, return to IDLE. A `start` arriving in the FIN cycle is ignored.
- A final partial block stops at `byte_idx` < 63; the unused buffer bytes are discarded.
- A `core_done` outside WAIT is ignored.

Optional Feature:
- Macro: KS_PREFETCH_EN.
- Defined:
  - A second 16-word buffer is added (ping-pong).
  - The next `core_start` issues on the first accepted beat of the current block, when more bytes remain beyond it and the counter has not overflowed.
  - If the core returns early, its block is held in the idle buffer.
  - When the current block's byte 63 is accepted and the next block is already held, `ks_valid` stays high with zero bubble.
  - Overflow is checked when prefetch is issued; `err` still sets only at the block boundary.
- Undefined: single buffer; exactly one bubble-free block at a time, with a minimum of 2 idle cycles plus core latency between blocks.

Decomposition:
- Shared package `chacha_pkg`:
  - `word_t` (logic[31:0])
  - `block_t` (word_t[3:0][3:0])
  - `BLOCK_BYTES`=64
  - `BLOCK_CTR_MAX`=32'hFFFF_FFFF
- Sub-module `ks_block_buffer`: the 16-word register with a load strobe and a 6-bit byte-index read mux. It is instantiated twice under KS_PREFETCH_EN.
- The FSM, length and counter logic live in `keystream_sequencer`.

Test Plan:
- msg_len=64, init_counter=1, `ks_ready` always high, core block words 0x03020100, 0x07060504, … -> one `core_start` with `core_counter`=1; bytes 0x00..0x3F in order; `ks_last` on byte 63; `done` 1 cycle later.
- msg_len=130, init_counter=7 -> three `core_start` pulses with counters 7, 8, 9; 130 bytes total; the third block stops after 2 bytes; `ks_last` on the 130th byte.
- msg_len=10, `ks_ready` toggling randomly -> `ks_byte`/`ks_last` stable while stalled; exactly 10 accepted beats, matching the unstalled reference.
- msg_len=0 -> no `core_start`; `done` pulses 1 cycle after `start`; `busy` goes high for 1 cycle only.
- msg_len=100, init_counter=32'hFFFF_FFFF -> one block streamed; after byte 63, `err`=1 and `done` pulses; no second `core_start`; `ks_last` never asserted.
- `rst` asserted in WAIT, then `core_done` arrives -> all outputs at reset values; `core_done` ignored; the next `start` with msg_len=4 completes normally with `err`=0.
